// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures an incoming asynchronous PWM waveform and recovers
//               its 8-bit duty code (0-255) and its period in clk cycles.
//               pwm_in is synchronised, edges are timed with a saturating
//               counter, and the duty code is computed by an 8-step
//               restoring serial divider: floor(high_len*256/period_len).
//               A missing rising edge for TIMEOUT_PERIODS nominal periods
//               reports signal loss with duty 0 or 255 from the held level.
// Ports       : clk          in   system clock
//               reset        in   synchronous, active-high reset
//               pwm_in       in   asynchronous PWM input
//               duty         out  last recovered duty code
//               period       out  last measured period (rise to rise), clk cycles
//               duty_valid   out  1-cycle strobe, duty/period updated
//               signal_lost  out  high while no valid PWM is being received
// Revision    : 1.0  initial release
// ============================================================================
module pwm_capture #(
    parameter int CLK_FREQ        = 27_000_000,
    parameter int PWM_FREQ        = 1000,
    parameter int TIMEOUT_PERIODS = 4,
    localparam int c_NOM   = CLK_FREQ / PWM_FREQ,
    localparam int c_TMO   = TIMEOUT_PERIODS * c_NOM,
    localparam int c_CNT_W = $clog2(c_TMO) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pwm_in,
    output logic [7:0]         duty,
    output logic [c_CNT_W-1:0] period,
    output logic               duty_valid,
    output logic               signal_lost
);

    localparam logic [c_CNT_W-1:0] c_TMO_V = c_CNT_W'(c_TMO);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_rise;
    logic w_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // ------------------------------------------------------------------
    // Edge-to-edge counter, saturating at the timeout value
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_cnt_max;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_cnt_max = (r_cnt == c_TMO_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= '0;
        end else if (!w_cnt_max) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_cnt_max) begin
                    w_state_next = ST_LOST;
                end
            end
            ST_LOST: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Edges are only meaningful while measuring and before the timeout fires;
    // a saturated counter would otherwise yield a bogus period.
    logic w_measure_ok;
    logic w_lost_act;
    logic r_busy;
    logic w_start;

    assign w_measure_ok = (r_state == ST_MEASURE) && !w_cnt_max;
    assign w_lost_act   = (r_state == ST_LOST);
    // The divider stays busy through its completion cycle, so a rise landing
    // on that cycle is dropped as an overrun.
    assign w_start      = w_measure_ok && w_rise && !r_busy;

    // High-phase length of the current period; a period without a fall
    // leaves it at zero.
    logic [c_CNT_W-1:0] r_high_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_high_len <= '0;
        end else if (w_rise) begin
            r_high_len <= '0;
        end else if (w_measure_ok && w_fall) begin
            r_high_len <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Restoring serial divider: one quotient bit per cycle, MSB first.
    // The remainder is kept below the divisor, so the shifted value always
    // fits in c_CNT_W+1 bits.
    // ------------------------------------------------------------------
    logic [2:0]         r_step;
    logic [c_CNT_W:0]   r_rem;
    logic [7:0]         r_quo;
    logic [c_CNT_W-1:0] r_div_per;
    logic [c_CNT_W:0]   w_rem_shift;
    logic [c_CNT_W:0]   w_divisor;
    logic               w_ge;
    logic [c_CNT_W:0]   w_rem_next;
    logic [7:0]         w_quo_next;
    logic               w_div_done;

    assign w_rem_shift = r_rem << 1;
    assign w_divisor   = {1'b0, r_div_per};
    assign w_ge        = (w_rem_shift >= w_divisor);
    assign w_rem_next  = w_ge ? (w_rem_shift - w_divisor) : w_rem_shift;
    assign w_quo_next  = {r_quo[6:0], w_ge};
    assign w_div_done  = r_busy && (r_step == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_step    <= 3'd0;
            r_rem     <= '0;
            r_quo     <= 8'd0;
            r_div_per <= '0;
        end else if (w_lost_act) begin
            // A timeout discards any division still in flight.
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_busy    <= 1'b1;
            r_step    <= 3'd0;
            r_rem     <= {1'b0, r_high_len};
            r_quo     <= 8'd0;
            r_div_per <= w_cnt_inc;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_step <= r_step + 3'd1;
            if (r_step == 3'd7) begin
                r_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. The final quotient bit is folded in on the 8th
    // step so the result appears 9 cycles after the rise pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            duty        <= 8'd0;
            period      <= '0;
            duty_valid  <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            duty_valid <= 1'b0;
            if (w_lost_act) begin
                duty        <= {8{r_s2}};
                period      <= '0;
                duty_valid  <= 1'b1;
                signal_lost <= 1'b1;
            end else if (w_div_done) begin
                duty        <= w_quo_next;
                period      <= r_div_per;
                duty_valid  <= 1'b1;
                signal_lost <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture (CLK_FREQ=1000,
//               PWM_FREQ=10 -> NOM=100, TMO=400). Expected results are
//               queued when the PWM stimulus is driven and compared when
//               duty_valid strobes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             pwm_in;
    logic [7:0]       duty;
    logic [CNT_W-1:0] period;
    logic             duty_valid;
    logic             signal_lost;

    pwm_capture #(
        .CLK_FREQ        (1000),
        .PWM_FREQ        (10),
        .TIMEOUT_PERIODS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .duty        (duty),
        .period      (period),
        .duty_valid  (duty_valid),
        .signal_lost (signal_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int duty;
        int period;
        bit lost;
        int at;     // expected cycle of duty_valid, -1 = not timed
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Stimulus-side model of which rises yield a result
    bit m_meas     = 1'b0;
    int m_rise     = 0;
    int m_fall     = 0;
    int m_last_acc = -1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int d, input int p, input bit l, input int at);
        exp_t e;
        e.duty   = d;
        e.period = p;
        e.lost   = l;
        e.at     = at;
        sb.push_back(e);
    endtask

    // A rise closes the previous period; it is reported only when the
    // divider (busy 9 cycles after each accepted rise) is free.
    task automatic do_rise();
        int p;
        if (m_meas && (cyc - m_last_acc >= 9)) begin
            p = cyc - m_rise;
            push_exp(((m_fall - m_rise) * 256) / p, p, 1'b0, cyc + 11);
            m_last_acc = cyc;
        end
        m_meas = 1'b1;
        m_rise = cyc;
        m_fall = cyc;
        pwm_in = 1'b1;
    endtask

    task automatic do_fall();
        m_fall = cyc;
        pwm_in = 1'b0;
    endtask

    task automatic drive_period(input int h, input int l);
        do_rise();
        tick(h);
        do_fall();
        tick(l);
    endtask

    // Output monitor / scoreboard
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (duty_valid) begin
            chk("no_back_to_back_valid", prev_valid, 0);
            chk("valid_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_duty", duty, e.duty);
                chk("sb_period", period, e.period);
                chk("sb_signal_lost", signal_lost, e.lost);
                if (e.at >= 0) chk("sb_latency", cyc, e.at);
            end
        end
        prev_valid <= duty_valid;
    end

    initial begin
        int lr;
        reset  = 1'b1;
        pwm_in = 1'b0;
        tick(3);
        chk("rst_duty", duty, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", duty_valid, 0);
        chk("rst_lost", signal_lost, 1);
        reset = 1'b0;
        tick(2);

        // 25/75 -> 64
        repeat (6) drive_period(25, 75);
        chk("t1_duty", duty, 64);
        chk("t1_period", period, 100);
        chk("t1_lost", signal_lost, 0);
        chk("t1_drained", sb.size(), 0);

        // 99/1 -> 253, then 1/99 -> 2
        repeat (4) drive_period(99, 1);
        chk("t2_duty_hi", duty, 253);
        repeat (4) drive_period(1, 99);
        chk("t2_duty_lo", duty, 2);

        // generator loopback code 128: 49/51 -> 125
        repeat (4) drive_period(49, 51);
        chk("t3_duty", duty, 125);
        chk("t3_period", period, 100);

        // period 6 -> 128, every other rise dropped
        repeat (9) drive_period(3, 3);
        chk("t5_duty", duty, 128);
        chk("t5_period", period, 6);

        // stop low -> lost, duty 0
        lr = m_rise;
        while (cyc < lr + 395) tick(1);
        chk("t4_low_not_yet_lost", signal_lost, 0);
        push_exp(0, 0, 1'b1, -1);
        m_meas = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        chk("t4_low_lost_reported", sb.size(), 0);
        chk("t4_low_lost", signal_lost, 1);
        chk("t4_low_duty", duty, 0);
        chk("t4_low_period", period, 0);

        // held high -> lost, duty 255
        do_rise();
        lr = m_rise;
        push_exp(255, 0, 1'b1, -1);
        m_meas = 1'b0;
        while (cyc < lr + 395) tick(1);
        chk("t4_high_not_yet_lost", signal_lost, 1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        chk("t4_high_lost_reported", sb.size(), 0);
        chk("t4_high_duty", duty, 255);

        // resume: valid again from the 2nd rise
        do_fall();
        tick(50);
        repeat (3) drive_period(25, 75);
        chk("t4_resume_lost", signal_lost, 0);
        chk("t4_resume_duty", duty, 64);

        // reset 4 clk into a divide
        do_rise();
        tick(6);
        reset = 1'b1;
        tick(1);
        chk("t6_duty", duty, 0);
        chk("t6_period", period, 0);
        chk("t6_valid", duty_valid, 0);
        chk("t6_lost", signal_lost, 1);
        sb.delete();
        m_meas     = 1'b0;
        m_last_acc = -1000;
        tick(2);
        reset = 1'b0;
        tick(3);
        do_fall();
        tick(30);
        chk("t6_no_stale_lost", signal_lost, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
